stopwatch_ctrl: RTL and testbench

Sequencing controller for the two-digit BCD seconds counter (BCD1 tens, BCD0 units, counts 00-99, synchronous Reset/Enable). It turns push-button levels into Start/Stop, Clear and Lap events and divides the system clock into a one-cycle count tick. It drives the counter's Enable and Reset, stops at a programmable limit, and freezes the display on Lap. It sits between the board keys and the counter/7-segment display path.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_edge_rise.sv | 30 +++
 rtl/stopwatch_ctrl.sv | 124 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared state encoding and constants for the stopwatch control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE  = 4'd9;
    localparam logic [7:0] LIMIT_OFF = 8'h00;

endpackage

`default_nettype wire

// File: rtl/stopwatch_edge_rise.sv
// ============================================================================
// Module      : edge_rise
// Description : Single-bit rising-edge detector; history resets high so a
//               level already asserted at reset release is not an event.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_rise (
    input  logic Clock,
    input  logic Reset,
    input  logic Level,
    output logic Rise
);

    logic r_prev;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= Level;
        end
    end

    assign Rise = Level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Key-event sequencer, tick prescaler, limit stop and lap hold
//               for a two-digit BCD seconds counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       StartStop,
    input  logic       Clear,
    input  logic       Lap,
    input  logic [3:0] LimBCD1,
    input  logic [3:0] LimBCD0,
    input  logic [3:0] CntBCD1,
    input  logic [3:0] CntBCD0,
    output logic       CountEnable,
    output logic       CountReset,
    output logic       Running,
    output logic       Done,
    output logic       Hold,
    output logic [3:0] DispBCD1,
    output logic [3:0] DispBCD0
);

    localparam logic [DIV_W-1:0] c_presc_last = DIV_W'(TICK_DIV - 1);

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_presc, w_presc_nxt;
    logic             r_count_enable, w_count_enable_nxt;
    logic             r_count_reset, w_count_reset_nxt;
    logic             r_hold, w_hold_nxt;
    logic [3:0]       r_disp1, r_disp0;

    logic w_ss_ev, w_clr_ev, w_lap_ev;
    logic [7:0] w_limit;
    logic w_lim_en, w_hit, w_wrap;

    edge_rise u_edge_ss  (.Clock(Clock), .Reset(Reset), .Level(StartStop), .Rise(w_ss_ev));
    edge_rise u_edge_clr (.Clock(Clock), .Reset(Reset), .Level(Clear),     .Rise(w_clr_ev));
    edge_rise u_edge_lap (.Clock(Clock), .Reset(Reset), .Level(Lap),       .Rise(w_lap_ev));

    // A limit with a non-decimal digit can never match, so treat it as off.
    assign w_limit  = {LimBCD1, LimBCD0};
    assign w_lim_en = (w_limit != LIMIT_OFF) && (LimBCD1 <= BCD_NINE) && (LimBCD0 <= BCD_NINE);
    assign w_hit    = w_lim_en && ({CntBCD1, CntBCD0} == w_limit);
    assign w_wrap   = (r_presc == c_presc_last);

    always_comb begin
        w_state_nxt        = r_state;
        w_presc_nxt        = r_presc;
        w_count_enable_nxt = 1'b0;
        w_count_reset_nxt  = 1'b0;
        w_hold_nxt         = r_hold;
        if (w_clr_ev) begin
            w_state_nxt       = IDLE;
            w_presc_nxt       = '0;
            w_hold_nxt        = 1'b0;
            w_count_reset_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ss_ev) w_state_nxt = RUN;
                end
                RUN: begin
                    if (w_hit) begin
                        // Prescaler freezes and hold is left as it is.
                        w_state_nxt = DONE;
                    end else begin
                        w_presc_nxt        = w_wrap ? '0 : r_presc + 1'b1;
                        w_count_enable_nxt = w_wrap;
                        if (w_ss_ev)       w_state_nxt = PAUSE;
                        else if (w_lap_ev) w_hold_nxt  = ~r_hold;
                    end
                end
                PAUSE: begin
                    if (w_ss_ev)       w_state_nxt = RUN;
                    else if (w_lap_ev) w_hold_nxt  = ~r_hold;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state        <= IDLE;
            r_presc        <= '0;
            r_count_enable <= 1'b0;
            r_count_reset  <= 1'b0;
            r_hold         <= 1'b0;
            r_disp1        <= 4'd0;
            r_disp0        <= 4'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_presc        <= w_presc_nxt;
            r_count_enable <= w_count_enable_nxt;
            r_count_reset  <= w_count_reset_nxt;
            r_hold         <= w_hold_nxt;
            if (!r_hold) begin
                r_disp1 <= CntBCD1;
                r_disp0 <= CntBCD0;
            end
        end
    end

    assign CountEnable = r_count_enable;
    assign CountReset  = r_count_reset;
    assign Running     = (r_state == RUN);
    assign Done        = (r_state == DONE);
    assign Hold        = r_hold;
    assign DispBCD1    = r_disp1;
    assign DispBCD0    = r_disp0;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed bench for stopwatch_ctrl with a BCD counter model
//               closing the loop (TICK_DIV = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       StartStop = 1'b0;
    logic       Clear = 1'b0;
    logic       Lap = 1'b0;
    logic [3:0] LimBCD1 = 4'd0;
    logic [3:0] LimBCD0 = 4'd0;
    logic [3:0] CntBCD1, CntBCD0;
    logic       CountEnable, CountReset, Running, Done, Hold;
    logic [3:0] DispBCD1, DispBCD0;

    int n_cmp = 0;
    int n_err = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .DIV_W(2)) dut (
        .Clock(Clock), .Reset(Reset), .StartStop(StartStop), .Clear(Clear), .Lap(Lap),
        .LimBCD1(LimBCD1), .LimBCD0(LimBCD0), .CntBCD1(CntBCD1), .CntBCD0(CntBCD0),
        .CountEnable(CountEnable), .CountReset(CountReset), .Running(Running), .Done(Done),
        .Hold(Hold), .DispBCD1(DispBCD1), .DispBCD0(DispBCD0)
    );

    always #5 Clock = ~Clock;

    // Two-digit BCD counter with synchronous reset/enable.
    always_ff @(posedge Clock) begin
        if (Reset || CountReset) begin
            CntBCD1 <= 4'd0;
            CntBCD0 <= 4'd0;
        end else if (CountEnable) begin
            if (CntBCD0 == 4'd9) begin
                CntBCD0 <= 4'd0;
                CntBCD1 <= (CntBCD1 == 4'd9) ? 4'd0 : CntBCD1 + 4'd1;
            end else begin
                CntBCD0 <= CntBCD0 + 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_ss();
        StartStop = 1'b1; step(); StartStop = 1'b0;
    endtask

    task automatic pulse_lap();
        Lap = 1'b1; step(); Lap = 1'b0;
    endtask

    task automatic wait_cnt(input logic [7:0] target, input int budget, input string tag);
        int n = 0;
        while ({CntBCD1, CntBCD0} != target && n < budget) begin
            step();
            n++;
        end
        chk(tag, {CntBCD1, CntBCD0}, target);
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_outputs", {CountEnable, CountReset, Running, Done, Hold, 3'b0}, 8'h00);
        chk("rst_disp", {DispBCD1, DispBCD0}, 8'h00);
        Reset = 1'b0;
        step();

        // 1: free run, tick every 4th cycle, count reaches 10
        pulse_ss();
        chk("s1_running", {7'd0, Running}, 8'd1);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("s1_tick", {7'd0, CountEnable}, {7'd0, ((i + 1) % 4 == 0)});
        end
        step();
        chk("s1_count10", {CntBCD1, CntBCD0}, 8'h10);
        chk("s1_running2", {7'd0, Running}, 8'd1);

        // Clear back to IDLE
        Clear = 1'b1; step();
        chk("clr_pulse", {CountReset, Running, 6'd0}, 8'h80);
        Clear = 1'b0; step();
        chk("clr_pulse_end", {7'd0, CountReset}, 8'd0);
        chk("clr_count", {CntBCD1, CntBCD0}, 8'h00);

        // 2: pause keeps prescaler phase
        pulse_ss();
        wait_cnt(8'h03, 30, "s2_reach03");
        pulse_ss();
        chk("s2_paused", {7'd0, Running}, 8'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("s2_no_tick", {7'd0, CountEnable}, 8'd0);
        end
        chk("s2_count_hold", {CntBCD1, CntBCD0}, 8'h03);
        pulse_ss();
        chk("s2_resume_r0", {CountEnable, Running, 6'd0}, 8'h40);
        step();
        chk("s2_resume_r1", {7'd0, CountEnable}, 8'd0);
        step();
        chk("s2_resume_r2", {7'd0, CountEnable}, 8'd1);
        step();
        chk("s2_count04", {CntBCD1, CntBCD0}, 8'h04);

        // 3: limit 12 -> DONE
        Clear = 1'b1; step(); Clear = 1'b0; step();
        LimBCD1 = 4'd1; LimBCD0 = 4'd2;
        pulse_ss();
        wait_cnt(8'h12, 100, "s3_reach12");
        chk("s3_not_done_yet", {7'd0, Done}, 8'd0);
        step();
        chk("s3_done", {Done, Running, 6'd0}, 8'h80);
        step(); step(); step(); step();
        chk("s3_count_stays", {CntBCD1, CntBCD0}, 8'h12);
        chk("s3_no_tick", {7'd0, CountEnable}, 8'd0);
        pulse_ss(); step();
        chk("s3_ss_ignored", {Done, Running, 6'd0}, 8'h80);
        Clear = 1'b1; step();
        chk("s3_clear", {CountReset, Done, Running, 5'd0}, 8'h80);
        Clear = 1'b0; step();
        chk("s3_clear_end", {7'd0, CountReset}, 8'd0);
        chk("s3_count00", {CntBCD1, CntBCD0}, 8'h00);
        LimBCD1 = 4'd0; LimBCD0 = 4'd0;

        // 4: lap hold
        pulse_ss();
        wait_cnt(8'h05, 40, "s4_reach05");
        pulse_lap();
        chk("s4_hold_on", {7'd0, Hold}, 8'd1);
        wait_cnt(8'h09, 30, "s4_reach09");
        chk("s4_disp_frozen", {DispBCD1, DispBCD0}, 8'h05);
        pulse_lap();
        chk("s4_hold_off", {7'd0, Hold}, 8'd0);
        chk("s4_disp_still", {DispBCD1, DispBCD0}, 8'h05);
        step();
        chk("s4_disp_follow", {DispBCD1, DispBCD0}, 8'h09);
        wait_cnt(8'h10, 10, "s4_reach10");
        chk("s4_disp_lag", {DispBCD1, DispBCD0}, 8'h09);
        step();
        chk("s4_disp_10", {DispBCD1, DispBCD0}, 8'h10);
        step();

        // 5: StartStop + Clear together on a wrap cycle
        StartStop = 1'b1; Clear = 1'b1; step();
        chk("s5_clear_wins", {CountReset, CountEnable, Running, 5'd0}, 8'h80);
        StartStop = 1'b0; Clear = 1'b0; step();
        chk("s5_after", {CountEnable, Running, 6'd0}, 8'h00);
        chk("s5_count00", {CntBCD1, CntBCD0}, 8'h00);

        // Key held through reset release
        StartStop = 1'b1;
        Reset = 1'b1; step(); step();
        Reset = 1'b0; step(); step(); step();
        chk("s5_held_key", {7'd0, Running}, 8'd0);
        StartStop = 1'b0; step();
        chk("s5_held_release", {7'd0, Running}, 8'd0);

        // 6: invalid limit -> free run through 99
        LimBCD1 = 4'hA; LimBCD0 = 4'h3;
        pulse_ss();
        wait_cnt(8'h99, 500, "s6_reach99");
        chk("s6_not_done99", {Done, Running, 6'd0}, 8'h40);
        wait_cnt(8'h00, 10, "s6_wrap00");
        chk("s6_not_done00", {Done, Running, 6'd0}, 8'h40);
        wait_cnt(8'h01, 10, "s6_reach01");
        step(); step();
        chk("s6_disp01", {DispBCD1, DispBCD0}, 8'h01);
        Reset = 1'b1;
        #1;
        chk("s6_async_ctl", {CountEnable, CountReset, Running, Done, Hold, 3'b0}, 8'h00);
        chk("s6_async_disp", {DispBCD1, DispBCD0}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
